// File: rtl/uart_imem_loader.sv
// Assembles UART bytes into little-endian 32-bit words, writes them to consecutive
// instruction-memory addresses and releases the core once the 0xFFFFFFFF terminator arrives.
module uart_imem_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 104200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              core_rst,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, WRITE, DONE, ERROR} state_t;

  state_t              state, state_nx;
  logic [1:0]          bidx, bidx_nx;
  logic [31:0]         asm_r, asm_nx;
  logic [IDLE_W-1:0]   idle, idle_nx;
  logic [ADDR_W:0]     wc_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [31:0]         wdata_nx;
  logic                we_nx, done_nx, crst_nx, ovf_nx;
  logic                accept;
  logic [31:0]         word;

  assign accept = uart_rx_valid && (state == LOAD || state == WRITE);
  assign word   = {uart_rx_data, asm_r[23:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      bidx       <= '0;
      asm_r      <= '0;
      idle       <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      write_done <= 1'b0;
      core_rst   <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      bidx       <= bidx_nx;
      asm_r      <= asm_nx;
      idle       <= idle_nx;
      word_count <= wc_nx;
      imem_we    <= we_nx;
      imem_addr  <= addr_nx;
      imem_wdata <= wdata_nx;
      write_done <= done_nx;
      core_rst   <= crst_nx;
      overflow   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bidx_nx  = bidx;
    asm_nx   = asm_r;
    idle_nx  = idle;
    wc_nx    = word_count;
    we_nx    = 1'b0;
    addr_nx  = imem_addr;
    wdata_nx = imem_wdata;
    done_nx  = write_done;
    crst_nx  = core_rst;
    ovf_nx   = overflow;

    if (state == WRITE) begin
      wc_nx    = word_count + 1'b1;
      state_nx = LOAD;
    end

    if (accept) begin
      asm_nx[{bidx, 3'b000} +: 8] = uart_rx_data;
      bidx_nx = bidx + 2'd1;
      idle_nx = '0;
      if (bidx == 2'd3) begin
        if (word == 32'hFFFF_FFFF) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          crst_nx  = 1'b0;
        end else if (word_count == DEPTH) begin
          state_nx = ERROR;
          ovf_nx   = 1'b1;
        end else begin
          wdata_nx = word;
          addr_nx  = word_count[ADDR_W-1:0];
          we_nx    = 1'b1;
          state_nx = WRITE;
        end
      end
    end else if (bidx != 2'd0) begin
      // A stalled partial word is dropped so the next byte starts a fresh word.
      if (idle == IDLE_LAST) begin
        bidx_nx = '0;
        idle_nx = '0;
      end else begin
        idle_nx = idle + 1'b1;
      end
    end

    if (uart_rx_break) begin
      state_nx = LOAD;
      bidx_nx  = '0;
      idle_nx  = '0;
      wc_nx    = '0;
      we_nx    = 1'b0;
      done_nx  = 1'b0;
      crst_nx  = 1'b1;
      ovf_nx   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed + randomized bench for uart_imem_loader; a word-level model predicts every
// memory write, terminator and overflow outcome.
module tb_uart_imem_loader;
  localparam int ADDR_W = 2;
  localparam int TO     = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_rx_valid, uart_rx_break;
  logic [7:0]        uart_rx_data;
  logic              imem_we, write_done, core_rst, overflow;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;

  uart_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .write_done(write_done), .core_rst(core_rst),
    .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int m_cnt = 0;
  bit m_done = 0, m_ovf = 0;
  int exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Every strobe seen must match the next write the model predicted.
  always @(negedge clk) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      if (exp_addr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        chk("mon_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
        chk("mon_data", imem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Returns one cycle after the 4th byte; overlap leaves the WRITE cycle open for the next byte.
  task automatic send_word(input logic [31:0] w, input bit overlap);
    bit wr;
    wr = !m_done && !m_ovf && w != 32'hFFFF_FFFF && m_cnt != DEPTH;
    if (wr) begin
      exp_addr.push_back(m_cnt);
      exp_data.push_back(w);
    end
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], i == 3 ? 0 : int'($urandom_range(0, 2)));
    if (m_done || m_ovf) begin
      chk("ignored_we", 32'(imem_we), 32'd0);
    end else if (w == 32'hFFFF_FFFF) begin
      m_done = 1;
      chk("done_wd", 32'(write_done), 32'd1);
      chk("done_crst", 32'(core_rst), 32'd0);
      chk("done_wc", 32'(word_count), 32'(m_cnt));
    end else if (m_cnt == DEPTH) begin
      m_ovf = 1;
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_crst", 32'(core_rst), 32'd1);
      chk("ovf_we", 32'(imem_we), 32'd0);
    end else begin
      chk("wr_we", 32'(imem_we), 32'd1);
      chk("wr_addr", 32'(imem_addr), 32'(m_cnt));
      chk("wr_data", imem_wdata, w);
      m_cnt++;
      if (!overlap) begin
        @(negedge clk);
        chk("wr_wc", 32'(word_count), 32'(m_cnt));
        chk("wr_we_low", 32'(imem_we), 32'd0);
      end
    end
  endtask

  task automatic send_partial(input int k);
    for (int i = 0; i < k; i++) send_byte(8'($urandom), i == k - 1 ? 0 : 1);
    repeat (TO + 2) @(negedge clk);
  endtask

  task automatic do_break();
    uart_rx_break = 1'b1;
    @(negedge clk);
    uart_rx_break = 1'b0;
    m_cnt = 0; m_done = 0; m_ovf = 0;
    chk("brk_wd", 32'(write_done), 32'd0);
    chk("brk_crst", 32'(core_rst), 32'd1);
    chk("brk_ovf", 32'(overflow), 32'd0);
    chk("brk_wc", 32'(word_count), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_wd"}, 32'(write_done), 32'd0);
    chk({tag, "_crst"}, 32'(core_rst), 32'd1);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; uart_rx_valid = 1'b0; uart_rx_break = 1'b0; uart_rx_data = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Basic load and terminator
    send_word(32'h0000_0000, 0);
    send_word(32'hfd01_0113, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h1234_5678, 0);

    // Reload after BREAK
    do_break();
    send_word(32'h0281_2623, 0);
    send_word(32'hFFFF_FFFF, 0);

    // Stalled partial word is discarded
    do_break();
    send_byte(8'h13, 1);
    send_byte(8'h01, 0);
    repeat (TO + 2) @(negedge clk);
    send_word(32'h0010_0793, 0);

    // Reset in the middle of a word
    send_byte(8'h26, 1);
    send_byte(8'h26, 0);
    rst = 1'b1;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    send_word(32'hfe04_2623, 0);

    // Byte during WRITE, then fill memory and overflow
    send_word(32'hA1A2_A3A4, 1);
    send_word(32'hB1B2_B3B4, 0);
    send_word(32'hC1C2_C3C4, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'h0BAD_F00D, 0);

    // Break beats a same-cycle byte
    uart_rx_valid = 1'b1; uart_rx_data = 8'hAA; uart_rx_break = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0; uart_rx_break = 1'b0;
    m_cnt = 0; m_done = 0; m_ovf = 0;
    chk("brkv_ovf", 32'(overflow), 32'd0);
    send_word(32'h1122_3344, 0);

    // Reset while the write strobe is high drops it at once
    send_word(32'h5566_7788, 1);
    #1 rst = 1'b1;
    #1 chk("rst_we_async", 32'(imem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_done = 0; m_ovf = 0;

    // Randomized loads
    for (int r = 0; r < 8; r++) begin
      int n;
      do_break();
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) send_partial($urandom_range(1, 3));
        send_word($urandom, bit'($urandom_range(0, 1)));
      end
      send_word(32'hFFFF_FFFF, 0);
    end

    repeat (3) @(negedge clk);
    chk("pending_writes", 32'(exp_addr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
